// File: rtl/div_pkg.sv
// Shared width, counter sizing and FSM encoding for the sequential divider.
package div_pkg;
    localparam int DW = 16;
    localparam int CW = $clog2(DW + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/div_core_seq_abs_mag.sv
// Splits a two's-complement value into its sign and unsigned magnitude.
module abs_mag
    import div_pkg::*;
#(
    parameter int W = DW
) (
    input  logic [W-1:0] value,
    output logic         sign,
    output logic [W-1:0] mag
);
    // The most negative value maps onto 2^(W-1), which still fits unsigned.
    assign sign = value[W-1];
    assign mag  = value[W-1] ? (~value + W'(1)) : value;
endmodule

// File: rtl/div_core_seq.sv
// Sequential restoring divider on operand magnitudes; one quotient bit per cycle.
// Handshake: start is sampled only in IDLE, busy covers RUN and DONE, and done pulses once when results become valid.
module div_core_seq
    import div_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic          div_by_zero,
    output logic [DW-1:0] Result_RAW,
    output logic [DW-1:0] Residue_RAW,
    output logic          Dividend_Sign,
    output logic          Divisor_Sign,
    output state_t        fsm_state
);
    state_t        state;
    logic [CW-1:0] cnt;
    logic [DW:0]   rem;
    logic [DW-1:0] quo;
    logic [DW-1:0] dvs_mag;

    logic          dvd_sign_in, dvs_sign_in;
    logic [DW-1:0] dvd_mag_in, dvs_mag_in;
    logic [DW+1:0] shifted;
    logic [DW+1:0] trial;

    abs_mag #(.W(DW)) u_abs_dividend (.value(dividend), .sign(dvd_sign_in), .mag(dvd_mag_in));
    abs_mag #(.W(DW)) u_abs_divisor  (.value(divisor),  .sign(dvs_sign_in), .mag(dvs_mag_in));

    // Trial subtraction is one bit wider than R so its MSB is the borrow.
    assign shifted = {rem, quo[DW-1]};
    assign trial   = shifted - {2'b00, dvs_mag};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            rem           <= '0;
            quo           <= '0;
            dvs_mag       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            div_by_zero   <= 1'b0;
            Dividend_Sign <= 1'b0;
            Divisor_Sign  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        Dividend_Sign <= dvd_sign_in;
                        Divisor_Sign  <= dvs_sign_in;
                        dvs_mag       <= dvs_mag_in;
                        cnt           <= '0;
                        busy          <= 1'b1;
                        if (dvs_mag_in == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                            quo         <= '1;
                            rem         <= {1'b0, dvd_mag_in};
                        end else begin
                            state       <= RUN;
                            div_by_zero <= 1'b0;
                            quo         <= dvd_mag_in;
                            rem         <= '0;
                        end
                    end
                end
                RUN: begin
                    if (!trial[DW+1]) begin
                        rem <= trial[DW:0];
                        quo <= {quo[DW-2:0], 1'b1};
                    end else begin
                        rem <= shifted[DW:0];
                        quo <= {quo[DW-2:0], 1'b0};
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(DW - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Result_RAW  = quo;
    assign Residue_RAW = rem[DW-1:0];
    assign fsm_state   = state;
endmodule

// File: tb/tb_div_core_seq.sv
// Directed bench for div_core_seq: hand-computed quotient/remainder vectors.
module tb_div_core_seq;
    import div_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] dividend, divisor;
    logic          busy, done, div_by_zero;
    logic [DW-1:0] Result_RAW, Residue_RAW;
    logic          Dividend_Sign, Divisor_Sign;
    state_t        fsm_state;

    int errors = 0;
    int checks = 0;

    div_core_seq dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .Result_RAW(Result_RAW), .Residue_RAW(Residue_RAW),
        .Dividend_Sign(Dividend_Sign), .Divisor_Sign(Divisor_Sign), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, scramble operands afterwards, and measure cycles to done.
    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, output int lat);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
        dividend = DW'($urandom_range(0, 65535));
        divisor  = DW'($urandom_range(0, 65535));
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic chk_op(input string tag, input int lat, input int exp_lat,
                          input logic [DW-1:0] q, input logic [DW-1:0] r,
                          input logic ds, input logic vs, input logic dz);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " quotient"}, Result_RAW, q);
        chk({tag, " remainder"}, Residue_RAW, r);
        chk({tag, " dividend sign"}, Dividend_Sign, ds);
        chk({tag, " divisor sign"}, Divisor_Sign, vs);
        chk({tag, " div_by_zero"}, div_by_zero, dz);
        chk({tag, " busy at done"}, busy, 1'b1);
        @(negedge clk);
        chk({tag, " done single pulse"}, done, 1'b0);
        chk({tag, " idle after done"}, busy, 1'b0);
        chk({tag, " quotient held"}, Result_RAW, q);
    endtask

    initial begin
        int lat;
        int pulses;
        int first_lat;
        rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        #1;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset dbz", div_by_zero, 1'b0);
        chk("reset quotient", Result_RAW, 16'h0000);
        chk("reset remainder", Residue_RAW, 16'h0000);
        chk("reset signs", {Dividend_Sign, Divisor_Sign}, 2'b00);
        chk("reset state", fsm_state, IDLE);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_op(16'd100, 16'd7, lat);
        chk_op("100/7", lat, 17, 16'd14, 16'd2, 1'b0, 1'b0, 1'b0);

        run_op(16'hFF9C, 16'd7, lat);
        chk_op("-100/7", lat, 17, 16'd14, 16'd2, 1'b1, 1'b0, 1'b0);

        run_op(16'h8000, 16'hFFFF, lat);
        chk_op("-32768/-1", lat, 17, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0);

        run_op(16'd0, 16'd5, lat);
        chk_op("0/5", lat, 17, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);

        run_op(16'd1000, 16'hFFDF, lat);
        chk_op("1000/-33", lat, 17, 16'd30, 16'd10, 1'b0, 1'b1, 1'b0);

        run_op(16'd5, 16'd9, lat);
        chk_op("5/9", lat, 17, 16'd0, 16'd5, 1'b0, 1'b0, 1'b0);

        run_op(16'd1234, 16'd0, lat);
        chk_op("1234/0", lat, 1, 16'hFFFF, 16'd1234, 1'b0, 1'b0, 1'b1);

        run_op(16'd9, 16'd3, lat);
        chk_op("9/3", lat, 17, 16'd3, 16'd0, 1'b0, 1'b0, 1'b0);

        // Start during RUN must be ignored.
        @(negedge clk);
        start = 1'b1; dividend = 16'd100; divisor = 16'd7;
        @(negedge clk);
        start = 1'b0;
        pulses = 0; first_lat = 0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 8) begin start = 1'b1; dividend = 16'd50; divisor = 16'd5; end
            if (k == 9) start = 1'b0;
            if (done) begin
                pulses++;
                if (first_lat == 0) first_lat = k;
                chk("ignored start quotient", Result_RAW, 16'd14);
                chk("ignored start remainder", Residue_RAW, 16'd2);
            end
            @(negedge clk);
        end
        chk("ignored start pulses", pulses, 1);
        chk("ignored start latency", first_lat, 17);

        // Reset in the middle of RUN.
        @(negedge clk);
        start = 1'b1; dividend = 16'hFF9C; divisor = 16'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midreset busy", busy, 1'b0);
        chk("midreset done", done, 1'b0);
        chk("midreset quotient", Result_RAW, 16'h0000);
        chk("midreset remainder", Residue_RAW, 16'h0000);
        chk("midreset signs", {Dividend_Sign, Divisor_Sign}, 2'b00);
        chk("midreset state", fsm_state, IDLE);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 3) rst = 1'b1;
            if (done) pulses++;
        end
        chk("midreset no done", pulses, 0);

        run_op(16'h7FFF, 16'h0001, lat);
        chk_op("7fff/1", lat, 17, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
